// File: rtl/adc_sdo_responder_pkg.sv
// ---------------------------------------------------------------------------
// adc_sdo_responder_pkg
//
// Shared definitions for the LTC2315-style serial ADC responder.
//
// Contents:
//   ADC_DATA_BITS   - default sample width
//   ADC_FRAME_BITS  - default number of SCK falling edges per frame
//   ADC_LEAD_ZEROS  - default number of zero bits sent ahead of the MSB
//   ADC_SYNC_STAGES - default depth of the SCK/CS input synchronisers
//   adc_state_t     - frame FSM state encoding (IDLE, SHIFT, TAIL)
// ---------------------------------------------------------------------------
package adc_sdo_responder_pkg;

    localparam int ADC_DATA_BITS   = 12;
    localparam int ADC_FRAME_BITS  = 16;
    localparam int ADC_LEAD_ZEROS  = 1;
    localparam int ADC_SYNC_STAGES = 2;

    // IDLE  : CS high, SDO held low, waiting for a CS fall
    // SHIFT : frame in progress, one bit shifted out per SCK fall
    // TAIL  : all bits sent, waiting for CS to rise to close the frame
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        TAIL  = 2'd2
    } adc_state_t;

endpackage : adc_sdo_responder_pkg

// File: rtl/adc_sdo_responder_sync_edge_det.sv
// ---------------------------------------------------------------------------
// sync_edge_det
//
// Brings one asynchronous input into the clk domain through a STAGES-deep
// flip-flop chain, then compares the synchronised level against one more
// register stage to produce single-cycle rise/fall strobes.
//
// Ports:
//   clk      in  - sampling clock
//   reset    in  - synchronous, active-high; fills the chain with RESET_VAL
//   async_in in  - asynchronous input
//   level    out - synchronised level
//   rise     out - one-cycle strobe on a synchronised 0->1 transition
//   fall     out - one-cycle strobe on a synchronised 1->0 transition
// ---------------------------------------------------------------------------
module sync_edge_det
    import adc_sdo_responder_pkg::*;
#(
    parameter int   STAGES    = ADC_SYNC_STAGES,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int                FILL_W    = $clog2(STAGES + 2);
    localparam logic [FILL_W-1:0] FILL_DONE = FILL_W'(STAGES + 1);

    logic [STAGES-1:0] chain;
    logic              prev;
    logic [FILL_W-1:0] fill_cnt;
    logic              primed;

    // After reset the chain and the edge register still hold RESET_VAL rather
    // than a real sample of the pin. Edges are suppressed until STAGES + 1
    // real samples have flowed through, so an input that was already at the
    // opposite level during reset does not look like a fresh transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            chain    <= {STAGES{RESET_VAL}};
            prev     <= RESET_VAL;
            fill_cnt <= '0;
        end else begin
            chain[0] <= async_in;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
            prev <= chain[STAGES-1];
            if (fill_cnt != FILL_DONE) begin
                fill_cnt <= fill_cnt + FILL_W'(1);
            end
        end
    end

    assign primed = (fill_cnt == FILL_DONE);
    assign level  = chain[STAGES-1];
    assign rise   = primed &  level & ~prev;
    assign fall   = primed & ~level &  prev;

endmodule : sync_edge_det

// File: rtl/adc_sdo_responder.sv
// ---------------------------------------------------------------------------
// adc_sdo_responder
//
// Far end of the ADC reader's SCK/CS/SDO link. Behaves like an LTC2315:
// on CS fall it loads a frame of LEAD_ZEROS zeros, a DATA_BITS sample and
// zero padding, then shifts one bit out per SCK falling edge. Samples come
// from a one-entry holding register or from an internal sawtooth.
//
// Ports:
//   clk_100      in   - sole clock
//   reset        in   - synchronous, active-high reset
//   adc_sck      in   - serial clock from the reader (asynchronous)
//   adc_cs       in   - active-low frame select (asynchronous)
//   adc_sdo      out  - serial data, 0 outside an active frame
//   adc_sdo_oe   out  - high while the synchronised CS is low
//   sample_data  in   - sample to transmit
//   sample_valid in   - sample_data is valid
//   sample_ready out  - holding register can accept a sample
//   pattern_en   in   - 1 selects the internal sawtooth (sampled at frame start)
//   frame_done   out  - one-cycle pulse when a complete frame ends
//   short_frame  out  - one-cycle pulse when CS rises before FRAME_BITS edges
//   underrun     out  - one-cycle pulse when a frame starts with no sample held
//   frame_count  out  - number of completed frames (wraps)
// ---------------------------------------------------------------------------
module adc_sdo_responder
    import adc_sdo_responder_pkg::*;
#(
    parameter int DATA_BITS   = ADC_DATA_BITS,
    parameter int FRAME_BITS  = ADC_FRAME_BITS,
    parameter int LEAD_ZEROS  = ADC_LEAD_ZEROS,
    parameter int SYNC_STAGES = ADC_SYNC_STAGES
) (
    input  logic                 clk_100,
    input  logic                 reset,
    input  logic                 adc_sck,
    input  logic                 adc_cs,
    output logic                 adc_sdo,
    output logic                 adc_sdo_oe,
    input  logic [DATA_BITS-1:0] sample_data,
    input  logic                 sample_valid,
    output logic                 sample_ready,
    input  logic                 pattern_en,
    output logic                 frame_done,
    output logic                 short_frame,
    output logic                 underrun,
    output logic [15:0]          frame_count
);

    localparam int               CNT_W    = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

    adc_state_t state, next_state;

    logic sck_level, sck_rise, sck_fall;
    logic cs_level, cs_rise, cs_fall;
    logic unused_sck;

    logic [FRAME_BITS-1:0] shift_reg;
    logic [FRAME_BITS-1:0] frame_word;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_BITS-1:0]  hold_data;
    logic                  hold_full;
    logic [DATA_BITS-1:0]  last_sample;
    logic [DATA_BITS-1:0]  saw_cnt;
    logic [DATA_BITS-1:0]  tx_value;

    logic accept;
    logic frame_start;
    logic frame_end;
    logic short_end;
    logic shift_en;
    logic frame_underrun;

    logic frame_done_q;
    logic short_frame_q;
    logic underrun_q;
    logic [15:0] frame_count_q;

    sync_edge_det #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sck_sync (
        .clk      (clk_100),
        .reset    (reset),
        .async_in (adc_sck),
        .level    (sck_level),
        .rise     (sck_rise),
        .fall     (sck_fall)
    );

    sync_edge_det #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_cs_sync (
        .clk      (clk_100),
        .reset    (reset),
        .async_in (adc_cs),
        .level    (cs_level),
        .rise     (cs_rise),
        .fall     (cs_fall)
    );

    // Only SCK falling edges move data; the level and rising strobe are unused.
    assign unused_sck = sck_level ^ sck_rise;

    assign sample_ready = ~pattern_en & ~hold_full;
    assign accept       = sample_valid & sample_ready;

    always_ff @(posedge clk_100) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A CS fall in TAIL means the CS high time was too short to be seen as a
    // rise, so the current frame is closed and a new one opened in one step.
    // A CS fall in SHIFT cannot happen while the synchronised CS is low and
    // is ignored.
    always_comb begin
        next_state  = state;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        short_end   = 1'b0;
        shift_en    = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    next_state  = SHIFT;
                    frame_start = 1'b1;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    next_state = IDLE;
                    short_end  = 1'b1;
                end else if (sck_fall) begin
                    shift_en = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        next_state = TAIL;
                    end
                end
            end
            TAIL: begin
                if (cs_rise) begin
                    next_state = IDLE;
                    frame_end  = 1'b1;
                end else if (cs_fall) begin
                    next_state  = SHIFT;
                    frame_end   = 1'b1;
                    frame_start = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Sample chosen for a frame that starts this cycle. A sample accepted on
    // the very cycle of the CS fall goes straight out and bypasses the
    // holding register. With nothing available the previous sample is resent.
    always_comb begin
        tx_value       = last_sample;
        frame_underrun = 1'b0;
        if (pattern_en) begin
            tx_value = saw_cnt;
        end else if (accept) begin
            tx_value = sample_data;
        end else if (hold_full) begin
            tx_value = hold_data;
        end else begin
            frame_underrun = 1'b1;
        end
    end

    always_comb begin
        frame_word = '0;
        frame_word[FRAME_BITS-1-LEAD_ZEROS -: DATA_BITS] = tx_value;
    end

    always_ff @(posedge clk_100) begin
        if (reset) begin
            shift_reg     <= '0;
            bit_cnt       <= '0;
            hold_data     <= '0;
            hold_full     <= 1'b0;
            last_sample   <= '0;
            saw_cnt       <= '0;
            frame_count_q <= '0;
            frame_done_q  <= 1'b0;
            short_frame_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            frame_done_q  <= frame_end;
            short_frame_q <= short_end;
            underrun_q    <= frame_start & frame_underrun;

            if (frame_end) begin
                frame_count_q <= frame_count_q + 16'd1;
            end

            if (frame_start) begin
                shift_reg   <= frame_word;
                bit_cnt     <= '0;
                last_sample <= tx_value;
                if (pattern_en) begin
                    saw_cnt <= saw_cnt + DATA_BITS'(1);
                end
            end else if (shift_en) begin
                shift_reg <= {shift_reg[FRAME_BITS-2:0], 1'b0};
                bit_cnt   <= bit_cnt + CNT_W'(1);
            end

            // Any non-pattern frame start drains the register, including the
            // same-cycle case where the incoming sample was sent directly.
            if (frame_start && !pattern_en) begin
                hold_full <= 1'b0;
            end else if (accept) begin
                hold_data <= sample_data;
                hold_full <= 1'b1;
            end
        end
    end

    assign adc_sdo     = (state == SHIFT) & shift_reg[FRAME_BITS-1];
    assign adc_sdo_oe  = ~cs_level;
    assign frame_done  = frame_done_q;
    assign short_frame = short_frame_q;
    assign underrun    = underrun_q;
    assign frame_count = frame_count_q;

endmodule : adc_sdo_responder

// File: tb/tb_adc_sdo_responder.sv
// ---------------------------------------------------------------------------
// tb_adc_sdo_responder
//
// Directed bench for adc_sdo_responder. Drives SCK at clk_100/8, captures
// adc_sdo just before each SCK falling edge into a 16-bit word and compares
// it against {lead zero, sample, 3'b000}. Pulse outputs are counted by a
// monitor and checked as deltas around each scenario.
// ---------------------------------------------------------------------------
module tb_adc_sdo_responder;

    logic        clk_100;
    logic        reset;
    logic        adc_sck;
    logic        adc_cs;
    logic        adc_sdo;
    logic        adc_sdo_oe;
    logic [11:0] sample_data;
    logic        sample_valid;
    logic        sample_ready;
    logic        pattern_en;
    logic        frame_done;
    logic        short_frame;
    logic        underrun;
    logic [15:0] frame_count;

    int checks   = 0;
    int failures = 0;

    int doneSeen       = 0;
    int shortSeen      = 0;
    int underrunSeen   = 0;
    int readyViolation = 0;

    adc_sdo_responder dut (
        .clk_100      (clk_100),
        .reset        (reset),
        .adc_sck      (adc_sck),
        .adc_cs       (adc_cs),
        .adc_sdo      (adc_sdo),
        .adc_sdo_oe   (adc_sdo_oe),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .pattern_en   (pattern_en),
        .frame_done   (frame_done),
        .short_frame  (short_frame),
        .underrun     (underrun),
        .frame_count  (frame_count)
    );

    initial clk_100 = 1'b0;
    always #5 clk_100 = ~clk_100;

    always @(negedge clk_100) begin
        if (frame_done)                 doneSeen++;
        if (short_frame)                shortSeen++;
        if (underrun)                   underrunSeen++;
        if (pattern_en && sample_ready) readyViolation++;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [15:0] frameWord(input logic [11:0] v);
        return {1'b0, v, 3'b000};
    endfunction

    task automatic loadSample(input logic [11:0] d);
        @(negedge clk_100);
        sample_data  = d;
        sample_valid = 1'b1;
        @(negedge clk_100);
        sample_valid = 1'b0;
    endtask

    // One CS-low frame with nEdges SCK falls at clk/8. When sameCycle is set,
    // sample_valid is raised for exactly the cycle in which the CS fall is
    // detected (two synchroniser stages after the pin changes).
    task automatic applyStimulus(input int nEdges, input bit sameCycle,
                                 input logic [11:0] scData,
                                 output logic [15:0] word, output logic oeSeen);
        word = '0;
        @(negedge clk_100);
        adc_cs = 1'b0;
        if (sameCycle) begin
            @(negedge clk_100);
            @(negedge clk_100);
            sample_data  = scData;
            sample_valid = 1'b1;
            @(negedge clk_100);
            sample_valid = 1'b0;
            @(negedge clk_100);
        end else begin
            repeat (4) @(negedge clk_100);
        end
        for (int i = 0; i < nEdges; i++) begin
            word[15-i] = adc_sdo;
            adc_sck = 1'b0;
            repeat (4) @(negedge clk_100);
            adc_sck = 1'b1;
            repeat (4) @(negedge clk_100);
        end
        oeSeen = adc_sdo_oe;
        adc_cs = 1'b1;
        repeat (6) @(negedge clk_100);
    endtask

    task automatic shortPulse();
        @(negedge clk_100);
        adc_cs = 1'b0;
        repeat (4) @(negedge clk_100);
        adc_cs = 1'b1;
        repeat (3) @(negedge clk_100);
    endtask

    initial begin
        logic [15:0] word;
        logic [15:0] expWord;
        logic        oeSeen;
        int d0, s0, u0;

        reset        = 1'b1;
        adc_sck      = 1'b1;
        adc_cs       = 1'b1;
        sample_data  = '0;
        sample_valid = 1'b0;
        pattern_en   = 1'b0;

        repeat (4) @(negedge clk_100);
        checkOutput("rst_sdo",       adc_sdo,     0);
        checkOutput("rst_oe",        adc_sdo_oe,  0);
        checkOutput("rst_done",      frame_done,  0);
        checkOutput("rst_short",     short_frame, 0);
        checkOutput("rst_underrun",  underrun,    0);
        checkOutput("rst_count",     frame_count, 0);
        reset = 1'b0;
        @(negedge clk_100);
        checkOutput("rst_ready", sample_ready, 1);
        repeat (4) @(negedge clk_100);

        // Nominal frame
        loadSample(12'hA5C);
        checkOutput("nom_ready_full", sample_ready, 0);
        d0 = doneSeen; u0 = underrunSeen;
        applyStimulus(16, 1'b0, 12'h000, word, oeSeen);
        checkOutput("nom_word",     word, frameWord(12'hA5C));
        checkOutput("nom_oe",       oeSeen, 1);
        checkOutput("nom_oe_off",   adc_sdo_oe, 0);
        checkOutput("nom_done",     doneSeen - d0, 1);
        checkOutput("nom_underrun", underrunSeen - u0, 0);
        checkOutput("nom_count",    frame_count, 1);
        checkOutput("nom_ready",    sample_ready, 1);

        // Underrun: no new sample, previous one is resent
        u0 = underrunSeen;
        applyStimulus(16, 1'b0, 12'h000, word, oeSeen);
        checkOutput("udr_word",     word, frameWord(12'hA5C));
        checkOutput("udr_underrun", underrunSeen - u0, 1);
        checkOutput("udr_count",    frame_count, 2);

        // Short frame after 7 edges, then a correct full frame
        loadSample(12'h3C1);
        d0 = doneSeen; s0 = shortSeen;
        applyStimulus(7, 1'b0, 12'h000, word, oeSeen);
        expWord = frameWord(12'h3C1);
        checkOutput("short_bits",  word[15:9], expWord[15:9]);
        checkOutput("short_pulse", shortSeen - s0, 1);
        checkOutput("short_done",  doneSeen - d0, 0);
        checkOutput("short_count", frame_count, 2);
        loadSample(12'h5A6);
        applyStimulus(16, 1'b0, 12'h000, word, oeSeen);
        checkOutput("after_short_word",  word, frameWord(12'h5A6));
        checkOutput("after_short_count", frame_count, 3);

        // Same-cycle accept on the CS fall detect
        u0 = underrunSeen;
        applyStimulus(16, 1'b1, 12'h7FF, word, oeSeen);
        checkOutput("same_word",     word, frameWord(12'h7FF));
        checkOutput("same_underrun", underrunSeen - u0, 0);
        checkOutput("same_ready",    sample_ready, 1);
        checkOutput("same_count",    frame_count, 4);

        // Reset in the middle of a frame, CS held low through reset
        loadSample(12'h0F0);
        d0 = doneSeen; s0 = shortSeen; u0 = underrunSeen;
        @(negedge clk_100);
        adc_cs = 1'b0;
        repeat (4) @(negedge clk_100);
        for (int i = 0; i < 5; i++) begin
            adc_sck = 1'b0;
            repeat (4) @(negedge clk_100);
            adc_sck = 1'b1;
            repeat (4) @(negedge clk_100);
        end
        reset = 1'b1;
        repeat (3) @(negedge clk_100);
        checkOutput("midrst_sdo",   adc_sdo, 0);
        checkOutput("midrst_count", frame_count, 0);
        reset = 1'b0;
        repeat (10) @(negedge clk_100);
        checkOutput("midrst_sdo_idle", adc_sdo, 0);
        adc_cs = 1'b1;
        repeat (6) @(negedge clk_100);
        checkOutput("midrst_done",     doneSeen - d0, 0);
        checkOutput("midrst_short",    shortSeen - s0, 0);
        checkOutput("midrst_underrun", underrunSeen - u0, 0);
        loadSample(12'h123);
        applyStimulus(16, 1'b0, 12'h000, word, oeSeen);
        checkOutput("midrst_word",  word, frameWord(12'h123));
        checkOutput("midrst_count1", frame_count, 1);

        // Pattern mode: 4097 frames, full reads near start and wrap
        pattern_en   = 1'b1;
        sample_data  = 12'hABC;
        sample_valid = 1'b1;
        d0 = doneSeen; s0 = shortSeen; u0 = underrunSeen;
        for (int f = 0; f < 4097; f++) begin
            if (f < 3 || f >= 4094) begin
                applyStimulus(16, 1'b0, 12'h000, word, oeSeen);
                checkOutput($sformatf("pattern_%0d", f), word, frameWord(12'(f)));
            end else begin
                shortPulse();
            end
        end
        sample_valid = 1'b0;
        checkOutput("pat_ready_viol", readyViolation, 0);
        checkOutput("pat_done",       doneSeen - d0, 6);
        checkOutput("pat_short",      shortSeen - s0, 4091);
        checkOutput("pat_underrun",   underrunSeen - u0, 0);
        checkOutput("pat_count",      frame_count, 7);
        pattern_en = 1'b0;
        @(negedge clk_100);
        checkOutput("pat_off_ready", sample_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_adc_sdo_responder
